gpio_irq_ctrl: RTL and testbench

Parametrised general-purpose pin controller for the system register bus: drives output pins with per-bit enable, synchronises, optionally polarity-inverts and debounces input pins, and raises a maskable interrupt on per-bit edge or level events with write-1-to-clear status. It sits between the external pin pads and the CPU register bus. It generalises the fixed 32-bit, 4-bit-debounce pin block to arbitrary width, a programmable debounce depth, per-bit debounce enable and per-bit edge/level/both-edge interrupt modes.

---
 rtl/gpio_irq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_irq_ctrl
//
// General-purpose pin controller on the system register bus.
//  - Drives output pins from the OUT register, with per-bit drive enable (OE).
//  - Brings in the asynchronous pins through a two-flop synchroniser. Each
//    input can be polarity-inverted (POL) and optionally debounced (DB_EN),
//    using a tick-sampled counter of depth DB_DEPTH.
//  - Raises a maskable interrupt on per-bit rising, falling or both edges, or
//    on level. Edge status is write-1-to-clear.
//
// Ports
//   sysclk   clock
//   reset    asynchronous, active-high reset
//   tick     debounce sample strobe, one sysclk wide
//   wr_n     register write strobe, active-low, sampled on sysclk
//   rd_n     register read enable, active-low (dout = all ones when high)
//   addr     register select (0..8 decoded, 9..15 read 0 / write ignored)
//   din      write data
//   dout     read data (combinational)
//   pin_in   raw pin inputs
//   pin_out  output pin values (OUT register)
//   pin_oe   output drive enables (OE register)
//   irq      interrupt request, |(IRQ_STAT & IRQ_EN)
// ---------------------------------------------------------------------------
module gpio_irq_ctrl #(
   parameter int WIDTH    = 32,
   parameter int DB_DEPTH = 4
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             tick,
   input  logic             wr_n,
   input  logic             rd_n,
   input  logic [3:0]       addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe,
   output logic             irq
);

   localparam logic [3:0] A_OUT      = 4'd0;
   localparam logic [3:0] A_OE       = 4'd1;
   localparam logic [3:0] A_POL      = 4'd2;
   localparam logic [3:0] A_DB_EN    = 4'd3;
   localparam logic [3:0] A_IRQ_EN   = 4'd4;
   localparam logic [3:0] A_IRQ_MODE = 4'd5;
   localparam logic [3:0] A_IRQ_BOTH = 4'd6;
   localparam logic [3:0] A_IRQ_STAT = 4'd7;
   localparam logic [3:0] A_IN       = 4'd8;

   // Counter value at which the next disagreeing tick is the accepting one
   localparam logic [3:0] DB_LAST = 4'(DB_DEPTH - 1);

   logic [WIDTH-1:0] out_q,      out_d;
   logic [WIDTH-1:0] oe_q,       oe_d;
   logic [WIDTH-1:0] pol_q,      pol_d;
   logic [WIDTH-1:0] db_en_q,    db_en_d;
   logic [WIDTH-1:0] irq_en_q,   irq_en_d;
   logic [WIDTH-1:0] irq_mode_q, irq_mode_d;
   logic [WIDTH-1:0] irq_both_q, irq_both_d;
   logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
   logic [WIDTH-1:0] sync1_q,    sync2_q;
   logic [WIDTH-1:0] filt_q,     filt_d;
   logic [WIDTH-1:0] prev_q;
   logic [3:0]       cnt_q [WIDTH];
   logic [3:0]       cnt_d [WIDTH];

   logic [WIDTH-1:0] s_s;
   logic [WIDTH-1:0] stat_clr_s;
   logic [WIDTH-1:0] edge_set_s;

   // Register write decode and W1C mask for IRQ_STAT
   always_comb begin
      out_d      = out_q;
      oe_d       = oe_q;
      pol_d      = pol_q;
      db_en_d    = db_en_q;
      irq_en_d   = irq_en_q;
      irq_mode_d = irq_mode_q;
      irq_both_d = irq_both_q;
      stat_clr_s = '0;
      if (!wr_n) begin
         case (addr)
            A_OUT:      out_d      = din;
            A_OE:       oe_d       = din;
            A_POL:      pol_d      = din;
            A_DB_EN:    db_en_d    = din;
            A_IRQ_EN:   irq_en_d   = din;
            A_IRQ_MODE: irq_mode_d = din;
            A_IRQ_BOTH: irq_both_d = din;
            A_IRQ_STAT: stat_clr_s = din;
            default:    stat_clr_s = '0;
         endcase
      end else begin
         stat_clr_s = '0;
      end
   end

   // Polarity-corrected synchronised input
   assign s_s = sync2_q ^ pol_q;

   // Input filter: pass-through, or accept a new level after DB_DEPTH
   // consecutive disagreeing ticks. A disabled bit keeps its counter at zero.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (!db_en_q[i]) begin
            filt_d[i] = s_s[i];
            cnt_d[i]  = 4'd0;
         end else if (tick) begin
            if (s_s[i] != filt_q[i]) begin
               if (cnt_q[i] == DB_LAST) begin
                  filt_d[i] = s_s[i];
                  cnt_d[i]  = 4'd0;
               end else begin
                  filt_d[i] = filt_q[i];
                  cnt_d[i]  = cnt_q[i] + 4'd1;
               end
            end else begin
               filt_d[i] = filt_q[i];
               cnt_d[i]  = 4'd0;
            end
         end else begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = cnt_q[i];
         end
      end
   end

   // Status update: in edge mode a new event wins over a same-cycle clear.
   // In level mode the status simply tracks the filtered input.
   always_comb begin
      edge_set_s = (filt_q & ~prev_q) | (irq_both_q & ~filt_q & prev_q);
      irq_stat_d = (irq_mode_q & filt_q)
                 | (~irq_mode_q & (edge_set_s | (irq_stat_q & ~stat_clr_s)));
   end

   // State registers
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         out_q      <= '0;
         oe_q       <= '0;
         pol_q      <= '0;
         db_en_q    <= '0;
         irq_en_q   <= '0;
         irq_mode_q <= '0;
         irq_both_q <= '0;
         irq_stat_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         filt_q     <= '0;
         prev_q     <= '0;
         cnt_q      <= '{default: 4'd0};
      end else begin
         out_q      <= out_d;
         oe_q       <= oe_d;
         pol_q      <= pol_d;
         db_en_q    <= db_en_d;
         irq_en_q   <= irq_en_d;
         irq_mode_q <= irq_mode_d;
         irq_both_q <= irq_both_d;
         irq_stat_q <= irq_stat_d;
         sync1_q    <= pin_in;
         sync2_q    <= sync1_q;
         filt_q     <= filt_d;
         prev_q     <= filt_q;
         cnt_q      <= cnt_d;
      end
   end

   // Combinational read mux; idle bus reads all ones
   always_comb begin
      dout = '1;
      if (!rd_n) begin
         case (addr)
            A_OUT:      dout = out_q;
            A_OE:       dout = oe_q;
            A_POL:      dout = pol_q;
            A_DB_EN:    dout = db_en_q;
            A_IRQ_EN:   dout = irq_en_q;
            A_IRQ_MODE: dout = irq_mode_q;
            A_IRQ_BOTH: dout = irq_both_q;
            A_IRQ_STAT: dout = irq_stat_q;
            A_IN:       dout = filt_q;
            default:    dout = '0;
         endcase
      end else begin
         dout = '1;
      end
   end

   assign pin_out = out_q;
   assign pin_oe  = oe_q;
   assign irq     = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
`timescale 1ns/1ps
module tb_gpio_irq_ctrl;
   localparam int W  = 32;
   localparam int DB = 4;

   logic          sysclk = 1'b0;
   logic          reset;
   logic          tick;
   logic          wr_n;
   logic          rd_n;
   logic [3:0]    addr;
   logic [W-1:0]  din;
   logic [W-1:0]  dout;
   logic [W-1:0]  pin_in;
   logic [W-1:0]  pin_out;
   logic [W-1:0]  pin_oe;
   logic          irq;

   always #10 sysclk = ~sysclk;

   gpio_irq_ctrl #(.WIDTH(W), .DB_DEPTH(DB)) dut (
      .sysclk  (sysclk),
      .reset   (reset),
      .tick    (tick),
      .wr_n    (wr_n),
      .rd_n    (rd_n),
      .addr    (addr),
      .din     (din),
      .dout    (dout),
      .pin_in  (pin_in),
      .pin_out (pin_out),
      .pin_oe  (pin_oe),
      .irq     (irq)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit tick_pat = 1'b0;
   bit last_tick = 1'b0;

   // Reference model: registers, two-stage input delay, accepted level, previous level,
   // and a count of consecutive disagreeing ticks per pin.
   logic [31:0] m_reg [0:6];
   logic [31:0] m_stat, m_f, m_p, m_sync1, m_sync2;
   int          m_run [W];
   logic [31:0] rv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] a);
      if (a <= 4'd6) return m_reg[a[2:0]];
      if (a == 4'd7) return m_stat;
      if (a == 4'd8) return m_f;
      return 32'h0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 7; i++) m_reg[i] = 32'h0;
      m_stat = 32'h0; m_f = 32'h0; m_p = 32'h0; m_sync1 = 32'h0; m_sync2 = 32'h0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
   endtask

   // One clock of the rules: filter, edge/level status, register writes
   task automatic model_clock();
      logic [31:0] s, nf, ev, clr, nstat;
      s  = m_sync2 ^ m_reg[2];
      nf = m_f;
      for (int i = 0; i < W; i++) begin
         if (!m_reg[3][i]) begin
            nf[i] = s[i];
            m_run[i] = 0;
         end else if (tick) begin
            if (s[i] != m_f[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == DB) begin
                  nf[i] = s[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      ev  = (m_f & ~m_p) | (m_reg[6] & m_p & ~m_f);
      clr = (!wr_n && addr == 4'd7) ? din : 32'h0;
      for (int i = 0; i < W; i++)
         nstat[i] = m_reg[5][i] ? m_f[i] : (ev[i] | (m_stat[i] & ~clr[i]));
      if (!wr_n && addr <= 4'd6) m_reg[addr[2:0]] = din;
      m_stat  = nstat;
      m_p     = m_f;
      m_f     = nf;
      m_sync2 = m_sync1;
      m_sync1 = pin_in;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] v);
      rd_n = 1'b0;
      addr = a;
      #1;
      v = dout;
      rd_n = 1'b1;
   endtask

   task automatic auto_check();
      int a;
      chk("pin_out", pin_out, m_reg[0]);
      chk("pin_oe", pin_oe, m_reg[1]);
      chk("irq", {31'h0, irq}, {31'h0, |(m_stat & m_reg[4])});
      rd(4'd8, rv);
      chk("rd_in", rv, m_f);
      a = cyc % 17;
      if (a == 16) begin
         rd_n = 1'b1;
         addr = 4'($urandom_range(0, 15));
         #1;
         chk("rd_idle", dout, 32'hFFFF_FFFF);
      end else begin
         rd(4'(a), rv);
         chk("rd_reg", rv, m_read(4'(a)));
      end
   endtask

   task automatic cycle();
      tick = tick_pat ? (cyc % 8 == 7) : ($urandom_range(0, 2) == 0);
      last_tick = tick;
      @(posedge sysclk);
      model_clock();
      cyc++;
      @(negedge sysclk);
      wr_n = 1'b1;
      auto_check();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_n = 1'b0;
      addr = a;
      din  = d;
      cycle();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      chk("rst_pin_out", pin_out, 32'h0);
      chk("rst_pin_oe", pin_oe, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      for (int a = 0; a < 9; a++) begin
         rd(4'(a), rv);
         chk("rst_reg", rv, 32'h0);
      end
      @(negedge sysclk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic align_tick();
      for (int i = 0; i < 8 && (cyc % 8) != 0; i++) cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; tick = 1'b0; wr_n = 1'b1; rd_n = 1'b1;
      addr = 4'd0; din = 32'h0; pin_in = 32'h0;
      model_reset();
      repeat (3) @(negedge sysclk);
      reset = 1'b0;
      idle(2);

      // Reset from a populated state, asynchronously
      wr(4'd0, 32'hA5A5_A5A5);
      wr(4'd1, 32'hFFFF_FFFF);
      chk("out_before_rst", pin_out, 32'hA5A5_A5A5);
      pulse_reset();
      idle(2);

      // Edge interrupt without debounce
      wr(4'd4, 32'hFFFF_FFFF);
      pin_in[3] = 1'b1;
      cycle(); rd(4'd8, rv); chk("edge_in_k", rv, 32'h0);
      cycle(); rd(4'd8, rv); chk("edge_in_k1", rv, 32'h0);
      cycle(); rd(4'd8, rv); chk("edge_in_k2", rv, 32'h8);
      rd(4'd7, rv); chk("edge_stat_k2", rv, 32'h0);
      cycle(); rd(4'd7, rv); chk("edge_stat_k3", rv, 32'h8);
      chk("edge_irq_k3", {31'h0, irq}, 32'h1);
      wr(4'd7, 32'h8);
      chk("w1c_irq", {31'h0, irq}, 32'h0);

      // Set/clear collision on bit 0
      pin_in[0] = 1'b1;
      idle(3);
      wr(4'd7, 32'h1);
      rd(4'd7, rv); chk("collision", rv, 32'h1);
      wr(4'd7, 32'h1);
      pin_in[0] = 1'b0;
      idle(4);

      // Debounce on bit 0 with a tick every 8 cycles
      wr(4'd3, 32'h1);
      tick_pat = 1'b1;
      align_tick();
      pin_in[0] = 1'b1;
      idle(16);
      pin_in[0] = 1'b0;
      idle(16);
      rd(4'd8, rv); chk("db_glitch_in", rv & 32'h1, 32'h0);
      rd(4'd7, rv); chk("db_glitch_stat", rv & 32'h1, 32'h0);
      align_tick();
      pin_in[0] = 1'b1;
      n = 0;
      for (int j = 0; j < 48; j++) begin
         cycle();
         if (last_tick && j >= 2) begin
            n++;
            if (n == 3) begin rd(4'd8, rv); chk("db_3rd_tick", rv & 32'h1, 32'h0); end
            if (n == 4) begin rd(4'd8, rv); chk("db_4th_tick", rv & 32'h1, 32'h1); end
         end
      end
      rd(4'd7, rv); chk("db_stat", rv & 32'h1, 32'h1);
      wr(4'd7, 32'h1);
      pin_in[0] = 1'b0;
      idle(48);
      wr(4'd3, 32'h0);
      tick_pat = 1'b0;

      // Both-edge mode on bit 1
      wr(4'd6, 32'h2);
      pin_in[1] = 1'b1;
      idle(4);
      rd(4'd7, rv); chk("both_rise", rv & 32'h2, 32'h2);
      wr(4'd7, 32'h2);
      rd(4'd7, rv); chk("both_clr", rv & 32'h2, 32'h0);
      pin_in[1] = 1'b0;
      idle(4);
      rd(4'd7, rv); chk("both_fall", rv & 32'h2, 32'h2);
      wr(4'd7, 32'h2);

      // Level mode with inverted polarity on bit 2
      wr(4'd2, 32'h4);
      wr(4'd5, 32'h4);
      idle(4);
      rd(4'd7, rv); chk("level_stat", rv & 32'h4, 32'h4);
      wr(4'd7, 32'h4);
      rd(4'd7, rv); chk("level_w1c", rv & 32'h4, 32'h4);

      // Bus decode
      rd(4'd12, rv); chk("rd_unmapped", rv, 32'h0);
      rd_n = 1'b1; #1; chk("rd_n_high", dout, 32'hFFFF_FFFF);
      cycle();
      wr(4'd8, 32'hFFFF_FFFF);
      rd(4'd8, rv); chk("in_readonly", rv, 32'hC);

      // Randomised traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) pulse_reset();
         wr_n   = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
         addr   = 4'($urandom_range(0, 15));
         din    = $urandom;
         pin_in = pin_in ^ ($urandom & $urandom & $urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
